control_escalado_secuencial: RTL and testbench
==============================================

// Module: control_escalado_secuencial
// PURPOSE
//  Frame-level scheduler for the single-pixel bilinear interpolator (modo_secuencial).
//  - Walks every output pixel of a downscaled image in raster order.
//  - Computes the Q8.8 source coordinate and fetches the 4 neighbours from a 1-read-port pixel memory.
//  - Pulses the interpolator, then writes the result to the output memory.
//  - Acts as the sequential baseline against which the parallel mode is measured.
// PARAMETERS
//  DIM_W   10  width of image dimensions (max 1023x1023)
//  ADDR_W  20  width of source/destination pixel addresses
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, asynchronous, active-low
//  inicio       in   1       pulse: start one frame (ignored while ocupado=1)
//  ancho_in     in   DIM_W   source width; alto_in in DIM_W: source height
//  ancho_out    in   DIM_W   dest width; alto_out in DIM_W: dest height
//  paso         in   16      q8_8_t source step per dest pixel (same for x and y), must be >=1.0
//  mem_rd       out  1       source read strobe
//  mem_dir      out  ADDR_W  source address = y*ancho_in + x
//  mem_dato     in   8       source data, valid exactly 1 cycle after mem_rd
//  iniciar      out  1       1-cycle pulse to interpolator
//  p00,p10,p01,p11 out 8     neighbour pixels to interpolator (held stable)
//  fx, fy       out  16      q8_8_t fractions {8'h00, frac[7:0]}
//  pixel_in     in   8       interpolator pixel_salida
//  wr_en        out  1       dest write strobe (1 cycle)
//  wr_dir       out  ADDR_W  dest address = oy*ancho_out + ox
//  wr_dato      out  8       = pixel_in during wr_en
//  ocupado      out  1       1 from cycle after accepted inicio until hecho
//  hecho        out  1       1-cycle pulse: frame complete
// BEHAVIOUR
//  - Reset: FSM=REPOSO; all outputs 0; ox, oy, and accumulators 0. Reset mid-frame aborts with no further writes.
//  - FSM per pixel, 12 cycles: CALC -> LEE00,CAP00 -> LEE10,CAP10 -> LEE01,CAP01 -> LEE11,CAP11
//    -> DISPARO -> ESPERA -> ESCRIBE -> (CALC | FIN).
//  - REPOSO: on inicio, latch the dimensions and paso; ox=oy=0; xs=ys=0.
//    - If ancho_out==0 or alto_out==0, go to FIN (no reads or writes); otherwise go to CALC.
//  - CALC: xi=xs[DIM_W+7:8], yi=ys[DIM_W+7:8]; x1=min(xi+1, ancho_in-1); y1=min(yi+1, alto_in-1).
//    - Clamp xi to ancho_in-1 and yi to alto_in-1 as well.
//    - fx={8'h00, xs[7:0]}; fy={8'h00, ys[7:0]}.
//  - LEExx: mem_rd=1 with the address of (xi,yi), (x1,yi), (xi,y1), (x1,y1) in turn.
//  - CAPxx: register mem_dato into the matching pNN.
//  - DISPARO: iniciar=1. ESPERA: interpolator loads its output. ESCRIBE: wr_en=1, wr_dato=pixel_in.
//  - Coordinate advance in ESCRIBE:
//    - ox+=1, xs+=paso.
//    - If ox==ancho_out-1: ox=0, xs=0, oy+=1, ys+=paso.
//    - If it was the last pixel, go to FIN.
//  - Accumulators xs, ys are DIM_W+8 bits wide; overflow is impossible for legal paso and dimensions.
//  - FIN: hecho=1 for 1 cycle, ocupado=0, return to REPOSO. A new inicio is accepted the next cycle.
//  - Only one of mem_rd, iniciar, wr_en is ever high in a given cycle.
//  - pNN, fx, fy hold from CAP/CALC through ESCRIBE.
//  - Frame latency: inicio sampled at edge 0 -> hecho high 12*N+1 cycles later, N = ancho_out*alto_out.
// CONFIGURATION
//  CONTADOR_CICLOS_EN defined:
//    - Adds output ciclos_total[31:0]: cleared on accepted inicio, +1 every cycle ocupado=1.
//    - Frozen at hecho; reset value 0.
//  CONTADOR_CICLOS_EN undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset mid-frame (after 3rd wr_en) -> all outputs 0 next cycle; no wr_en until a new inicio.
//  2. 4x4 src, 2x2 dst, paso=16'h0200, ramp memory -> 4 writes at wr_dir 0..3.
//     - Source points (0,0), (2,0), (0,2), (2,2); fx=fy=0.
//     - hecho 49 cycles after inicio.
//  3. 3x1 src, 2x1 dst, paso=16'h0180 -> pixel 1 fetches x=1 and x=2 with fx=16'h0080.
//     - src {0,100,200} -> wr_dato 150.
//  4. Right/bottom edge: 2x2 src, 2x2 dst, paso=16'h0100 -> pixel (1,1) reads addr 3 four times.
//     - wr_dato equals src[3].
//  5. ancho_out=0 with inicio -> hecho 1 cycle later, zero mem_rd/wr_en.
//     - A second inicio pulse while ocupado is ignored.
//  6. With CONTADOR_CICLOS_EN, case 2 -> ciclos_total=48 at hecho.

Source files
------------

// File: rtl/control_escalado_secuencial.sv
// control_escalado_secuencial: raster-order bilinear downscale scheduler (4 reads, fire, write per pixel).
// Optional CONTADOR_CICLOS_EN adds o_ciclos_total, a busy-cycle counter frozen at o_hecho.
module control_escalado_secuencial #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inicio,
  input  logic [DIM_W-1:0]  i_ancho_in,
  input  logic [DIM_W-1:0]  i_alto_in,
  input  logic [DIM_W-1:0]  i_ancho_out,
  input  logic [DIM_W-1:0]  i_alto_out,
  input  logic [15:0]       i_paso,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_dir,
  input  logic [7:0]        i_mem_dato,
  output logic              o_iniciar,
  output logic [7:0]        o_p00,
  output logic [7:0]        o_p10,
  output logic [7:0]        o_p01,
  output logic [7:0]        o_p11,
  output logic [15:0]       o_fx,
  output logic [15:0]       o_fy,
  input  logic [7:0]        i_pixel_in,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_dir,
  output logic [7:0]        o_wr_dato,
  output logic              o_ocupado,
`ifdef CONTADOR_CICLOS_EN
  output logic [31:0]       o_ciclos_total,
`endif
  output logic              o_hecho
);
  typedef enum logic [3:0] {
    REPOSO, CALC, LEE00, CAP00, LEE10, CAP10, LEE01, CAP01, LEE11, CAP11,
    DISPARO, ESPERA, ESCRIBE, FIN
  } estado_t;
  estado_t r_estado, w_sig;
  logic [DIM_W-1:0] r_ancho_in, r_alto_in, r_ancho_out, r_alto_out;
  logic [15:0] r_paso;
  logic [DIM_W-1:0] r_ox, r_oy, r_xi, r_x1, r_yi, r_y1;
  logic [DIM_W+7:0] r_xs, r_ys;
  logic [7:0] r_p00, r_p10, r_p01, r_p11, r_fx, r_fy;
  logic [DIM_W-1:0] w_xmax, w_ymax, w_xe, w_ye, w_xi, w_yi, w_x1, w_y1, w_sx, w_sy;
  logic w_acepta, w_fin_fila, w_ultimo;
  assign w_acepta   = (r_estado == REPOSO) && i_inicio;
  assign w_fin_fila = r_ox == r_ancho_out - DIM_W'(1);
  assign w_ultimo   = w_fin_fila && (r_oy == r_alto_out - DIM_W'(1));
  // Integer source coordinate and its +1 neighbour, both clamped inside the image
  assign w_xmax = r_ancho_in - DIM_W'(1);
  assign w_ymax = r_alto_in - DIM_W'(1);
  assign w_xe   = r_xs[DIM_W+7:8];
  assign w_ye   = r_ys[DIM_W+7:8];
  assign w_xi   = (w_xe > w_xmax) ? w_xmax : w_xe;
  assign w_yi   = (w_ye > w_ymax) ? w_ymax : w_ye;
  assign w_x1   = (w_xi >= w_xmax) ? w_xmax : w_xi + DIM_W'(1);
  assign w_y1   = (w_yi >= w_ymax) ? w_ymax : w_yi + DIM_W'(1);
  always_comb begin
    w_sig = r_estado;
    case (r_estado)
      REPOSO:  w_sig = !i_inicio ? REPOSO :
                       (i_ancho_out == '0 || i_alto_out == '0) ? FIN : CALC;
      ESCRIBE: w_sig = w_ultimo ? FIN : CALC;
      FIN:     w_sig = REPOSO;
      default: w_sig = estado_t'(r_estado + 4'd1);
    endcase
  end
  assign o_mem_rd  = r_estado inside {LEE00, LEE10, LEE01, LEE11};
  assign o_iniciar = r_estado == DISPARO;
  assign o_wr_en   = r_estado == ESCRIBE;
  assign o_hecho   = r_estado == FIN;
  assign o_ocupado = !(r_estado inside {REPOSO, FIN});
  assign w_sx      = (r_estado inside {LEE10, LEE11}) ? r_x1 : r_xi;
  assign w_sy      = (r_estado inside {LEE01, LEE11}) ? r_y1 : r_yi;
  assign o_mem_dir = o_mem_rd ? ADDR_W'(w_sy) * ADDR_W'(r_ancho_in) + ADDR_W'(w_sx) : '0;
  assign o_wr_dir  = o_wr_en ? ADDR_W'(r_oy) * ADDR_W'(r_ancho_out) + ADDR_W'(r_ox) : '0;
  assign o_wr_dato = o_wr_en ? i_pixel_in : '0;
  assign o_p00 = r_p00;
  assign o_p10 = r_p10;
  assign o_p01 = r_p01;
  assign o_p11 = r_p11;
  assign o_fx  = {8'h00, r_fx};
  assign o_fy  = {8'h00, r_fy};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= REPOSO;
      r_ancho_in  <= '0;
      r_alto_in   <= '0;
      r_ancho_out <= '0;
      r_alto_out  <= '0;
      r_paso      <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_xs        <= '0;
      r_ys        <= '0;
      r_xi        <= '0;
      r_x1        <= '0;
      r_yi        <= '0;
      r_y1        <= '0;
      r_fx        <= '0;
      r_fy        <= '0;
      r_p00       <= '0;
      r_p10       <= '0;
      r_p01       <= '0;
      r_p11       <= '0;
    end else begin
      r_estado <= w_sig;
      if (w_acepta) begin
        r_ancho_in  <= i_ancho_in;
        r_alto_in   <= i_alto_in;
        r_ancho_out <= i_ancho_out;
        r_alto_out  <= i_alto_out;
        r_paso      <= i_paso;
        r_ox        <= '0;
        r_oy        <= '0;
        r_xs        <= '0;
        r_ys        <= '0;
      end
      if (r_estado == CALC) begin
        r_xi <= w_xi;
        r_x1 <= w_x1;
        r_yi <= w_yi;
        r_y1 <= w_y1;
        r_fx <= r_xs[7:0];
        r_fy <= r_ys[7:0];
      end
      if (r_estado == CAP00) r_p00 <= i_mem_dato;
      if (r_estado == CAP10) r_p10 <= i_mem_dato;
      if (r_estado == CAP01) r_p01 <= i_mem_dato;
      if (r_estado == CAP11) r_p11 <= i_mem_dato;
      if (r_estado == ESCRIBE) begin
        r_ox <= w_fin_fila ? '0 : r_ox + DIM_W'(1);
        r_xs <= w_fin_fila ? '0 : r_xs + (DIM_W+8)'(r_paso);
        if (w_fin_fila) begin
          r_oy <= r_oy + DIM_W'(1);
          r_ys <= r_ys + (DIM_W+8)'(r_paso);
        end
      end
    end
  end
`ifdef CONTADOR_CICLOS_EN
  logic [31:0] r_ciclos;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ciclos <= '0;
    else if (w_acepta) r_ciclos <= '0;
    else if (o_ocupado) r_ciclos <= r_ciclos + 32'd1;
  end
  assign o_ciclos_total = r_ciclos;
`endif
endmodule

// File: tb/tb_control_escalado_secuencial.sv
// tb_control_escalado_secuencial: scoreboard bench, directed frames with hand-computed reads and writes.
module tb_control_escalado_secuencial;
  logic clk = 0, rst_n = 0, i_inicio = 0;
  logic [9:0] i_ancho_in = 0, i_alto_in = 0, i_ancho_out = 0, i_alto_out = 0;
  logic [15:0] i_paso = 0;
  logic o_mem_rd, o_iniciar, o_wr_en, o_ocupado, o_hecho;
  logic [19:0] o_mem_dir, o_wr_dir;
  logic [7:0] i_mem_dato = 0, i_pixel_in = 0, o_wr_dato, o_p00, o_p10, o_p01, o_p11;
  logic [15:0] o_fx, o_fy;
  logic [31:0] ciclos = 0;
  typedef struct packed {
    logic [19:0] dir;
    logic [7:0] dato;
    logic [15:0] fx;
    logic [15:0] fy;
  } wr_t;
  logic [19:0] q_rd[$];
  wr_t q_wr[$];
  logic [7:0] mem[64];
  int n_chk = 0, n_err = 0, n_rd = 0, n_wr = 0;
  control_escalado_secuencial dut (
    .clk(clk), .rst_n(rst_n), .i_inicio(i_inicio),
    .i_ancho_in(i_ancho_in), .i_alto_in(i_alto_in),
    .i_ancho_out(i_ancho_out), .i_alto_out(i_alto_out), .i_paso(i_paso),
    .o_mem_rd(o_mem_rd), .o_mem_dir(o_mem_dir), .i_mem_dato(i_mem_dato),
    .o_iniciar(o_iniciar), .o_p00(o_p00), .o_p10(o_p10), .o_p01(o_p01), .o_p11(o_p11),
    .o_fx(o_fx), .o_fy(o_fy), .i_pixel_in(i_pixel_in),
    .o_wr_en(o_wr_en), .o_wr_dir(o_wr_dir), .o_wr_dato(o_wr_dato),
    .o_ocupado(o_ocupado),
`ifdef CONTADOR_CICLOS_EN
    .o_ciclos_total(ciclos),
`endif
    .o_hecho(o_hecho)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] bil(input int a, b, c, d, fx, fy);
    int top, bot;
    top = a * (256 - fx) + b * fx;
    bot = c * (256 - fx) + d * fx;
    return 8'((top * (256 - fy) + bot * fy) >> 16);
  endfunction
  // Source memory with 1-cycle read latency and a reference bilinear interpolator
  always @(posedge clk) begin
    if (o_mem_rd) i_mem_dato <= mem[o_mem_dir[5:0]];
    if (o_iniciar) i_pixel_in <= bil(o_p00, o_p10, o_p01, o_p11, o_fx, o_fy);
  end
  always @(negedge clk) begin
    if (int'(o_mem_rd) + int'(o_iniciar) + int'(o_wr_en) > 1) chk("strobe_onehot", 1, 0);
    if (o_mem_rd) begin
      n_rd++;
      if (q_rd.size() == 0) chk("unexpected_rd", o_mem_dir, 20'hfffff);
      else chk("rd_dir", o_mem_dir, q_rd.pop_front());
    end
    if (o_wr_en) begin
      n_wr++;
      if (q_wr.size() == 0) chk("unexpected_wr", o_wr_dir, 20'hfffff);
      else chk("wr", {o_wr_dir, o_wr_dato, o_fx, o_fy}, q_wr.pop_front());
    end
  end
  task automatic cfg(input int aw, ah, bw, bh, input logic [15:0] p);
    i_ancho_in = 10'(aw); i_alto_in = 10'(ah);
    i_ancho_out = 10'(bw); i_alto_out = 10'(bh); i_paso = p;
  endtask
  task automatic exp_rd(input int a, b, c, d);
    q_rd.push_back(20'(a)); q_rd.push_back(20'(b));
    q_rd.push_back(20'(c)); q_rd.push_back(20'(d));
  endtask
  task automatic exp_wr(input int dir, dato, fx, fy);
    q_wr.push_back({20'(dir), 8'(dato), 16'(fx), 16'(fy)});
  endtask
  task automatic frame(input string name, input int exp_n, input bit pulse);
    int n;
    @(negedge clk) i_inicio = 1;
    @(posedge clk) #1 i_inicio = 0;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk) n++;
      if (n == 1 && exp_n > 1) chk({name, "_ocupado"}, o_ocupado, 1);
      if (pulse) i_inicio = (n == 5);
      if (o_hecho) break;
    end
    chk({name, "_latency"}, n, exp_n);
    chk({name, "_ocupado_at_hecho"}, o_ocupado, 0);
`ifdef CONTADOR_CICLOS_EN
    chk({name, "_ciclos"}, ciclos, exp_n - 1);
`endif
  endtask
  task automatic drain(input string name, input int cyc);
    repeat (cyc) @(negedge clk);
    chk({name, "_rd_left"}, q_rd.size(), 0);
    chk({name, "_wr_left"}, q_wr.size(), 0);
  endtask
  initial begin
    int rd0, wr0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {o_mem_rd, o_iniciar, o_wr_en, o_ocupado, o_hecho, o_mem_dir, o_wr_dir}, 0);
    chk("rst_data", {o_p00, o_p11, o_fx, o_fy, o_wr_dato, ciclos}, 0);
    rst_n = 1;
    // 4x4 ramp down to 2x2 at step 2.0
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    cfg(4, 4, 2, 2, 16'h0200);
    exp_rd(0, 1, 4, 5); exp_rd(2, 3, 6, 7); exp_rd(8, 9, 12, 13); exp_rd(10, 11, 14, 15);
    exp_wr(0, 0, 0, 0); exp_wr(1, 2, 0, 0); exp_wr(2, 8, 0, 0); exp_wr(3, 10, 0, 0);
    frame("ramp", 49, 0);
    drain("ramp", 5);
    // Reset after the third write aborts the frame
    exp_rd(0, 1, 4, 5); exp_rd(2, 3, 6, 7); exp_rd(8, 9, 12, 13);
    exp_wr(0, 0, 0, 0); exp_wr(1, 2, 0, 0); exp_wr(2, 8, 0, 0);
    rd0 = n_rd; wr0 = n_wr;
    @(negedge clk) i_inicio = 1;
    @(negedge clk) i_inicio = 0;
    for (int k = 0; k < 200 && n_wr - wr0 < 3; k++) @(negedge clk);
    @(posedge clk) #1 rst_n = 0;
    @(negedge clk);
    chk("abort_outs", {o_mem_rd, o_iniciar, o_wr_en, o_ocupado, o_hecho, o_mem_dir, o_wr_dir}, 0);
    chk("abort_data", {o_p00, o_p10, o_p01, o_p11, o_fx, o_fy, o_wr_dato}, 0);
    rst_n = 1;
    drain("abort", 40);
    chk("abort_wr_count", n_wr - wr0, 3);
    chk("abort_rd_count", n_rd - rd0, 12);
    // 3x1 to 2x1 at step 1.5, with an ignored inicio mid-frame
    mem[0] = 0; mem[1] = 100; mem[2] = 200;
    cfg(3, 1, 2, 1, 16'h0180);
    exp_rd(0, 1, 0, 1); exp_rd(1, 2, 1, 2);
    exp_wr(0, 0, 0, 0); exp_wr(1, 150, 16'h0080, 0);
    rd0 = n_rd;
    frame("frac", 25, 1);
    drain("frac", 30);
    chk("frac_no_restart", n_rd - rd0, 8);
    chk("frac_idle", o_ocupado, 0);
    // Right/bottom clamping
    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    cfg(2, 2, 2, 2, 16'h0100);
    exp_rd(0, 1, 2, 3); exp_rd(1, 1, 3, 3); exp_rd(2, 3, 2, 3); exp_rd(3, 3, 3, 3);
    exp_wr(0, 10, 0, 0); exp_wr(1, 20, 0, 0); exp_wr(2, 30, 0, 0); exp_wr(3, 40, 0, 0);
    frame("edge", 49, 0);
    drain("edge", 5);
    // Empty destination
    cfg(4, 4, 0, 2, 16'h0100);
    rd0 = n_rd; wr0 = n_wr;
    frame("empty", 1, 0);
    drain("empty", 10);
    chk("empty_traffic", (n_rd - rd0) + (n_wr - wr0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
